// File: rtl/mem_responder.sv
// Byte-addressed memory responder serving a fetch port and a data port, one request at a time,
// with a fixed access latency and RV32 load/store sizing.
module mem_responder #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned LAT      = 2,
    parameter bit          DATA_PRI = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = (LAT > 2) ? $clog2(LAT) : 1;
    localparam int unsigned CNT_INIT = (LAT > 1) ? LAT - 2 : 0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            port_q;   // 1: data port owns the access
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     wdata_q;

    logic [7:0]      mem [DEPTH];

    logic            accept, pick_d, enter_resp, err;
    logic            cur_data, cur_we;
    logic [AW-1:0]   cur_addr, a1, a2, a3;
    logic [2:0]      cur_f3;
    logic [31:0]     cur_wdata, word, load_val;
    logic [7:0]      b0, b1, b2, b3;
    logic            unused_bits;

    assign unused_bits = ^{if_addr[31:AW], if_addr[0], d_addr[31:AW]};

    assign accept = (state_q == StIdle) && (if_req || d_req);
    assign pick_d = d_req && (DATA_PRI || !if_req);

    // In IDLE the live winner is used so that LAT=1 can complete straight from acceptance.
    always_comb begin
        cur_data  = port_q;
        cur_addr  = addr_q;
        cur_we    = we_q;
        cur_f3    = f3_q;
        cur_wdata = wdata_q;
        if (state_q == StIdle) begin
            cur_data  = pick_d;
            cur_addr  = pick_d ? d_addr[AW-1:0] : {if_addr[AW-1:1], 1'b0};
            cur_we    = d_we;
            cur_f3    = d_funct3;
            cur_wdata = d_wdata;
        end
    end

    assign enter_resp = ((state_q == StIdle) && accept && (LAT == 1)) ||
                        ((state_q == StWait) && (cnt_q == '0));

    assign a1   = cur_addr + AW'(1);
    assign a2   = cur_addr + AW'(2);
    assign a3   = cur_addr + AW'(3);
    assign b0   = mem[cur_addr];
    assign b1   = mem[a1];
    assign b2   = mem[a2];
    assign b3   = mem[a3];
    assign word = {b3, b2, b1, b0};

    always_comb begin
        err = 1'b0;
        if (cur_f3 == 3'b011 || cur_f3 == 3'b110 || cur_f3 == 3'b111) err = 1'b1;
        if (cur_f3[1:0] == 2'b01 && cur_addr[0]) err = 1'b1;
        if (cur_f3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) err = 1'b1;
    end

    always_comb begin
        load_val = '0;
        case (cur_f3)
            3'b000:  load_val = {{24{b0[7]}}, b0};
            3'b001:  load_val = {{16{b1[7]}}, b1, b0};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'd0, b0};
            3'b101:  load_val = {16'd0, b1, b0};
            default: load_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_data && cur_we && !err) begin
            mem[cur_addr] <= cur_wdata[7:0];
            if (cur_f3[1:0] != 2'b00) mem[a1] <= cur_wdata[15:8];
            if (cur_f3[1:0] == 2'b10) begin
                mem[a2] <= cur_wdata[23:16];
                mem[a3] <= cur_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            port_q   <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            f3_q     <= '0;
            wdata_q  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            busy     <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        port_q  <= cur_data;
                        addr_q  <= cur_addr;
                        we_q    <= cur_we;
                        f3_q    <= cur_f3;
                        wdata_q <= cur_wdata;
                        busy    <= 1'b1;
                        state_q <= StWait;
                        cnt_q   <= CW'(CNT_INIT);
                    end
                end
                StWait: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                StResp: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                state_q <= StResp;
                busy    <= 1'b1;
                if (cur_data) begin
                    d_ack   <= 1'b1;
                    d_err   <= err;
                    d_rdata <= (err || cur_we) ? 32'd0 : load_val;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= word;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH=1024, LAT=2, DATA_PRI=1).
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_responder #(.DEPTH(1024), .LAT(2), .DATA_PRI(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_funct3 (d_funct3),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Drives one data request and waits (bounded) for d_ack; cyc=99 on timeout.
    task automatic do_data(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int cyc);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = addr; d_funct3 = f3; d_wdata = wd;
        cyc = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (d_ack) begin
                cyc = c;
                break;
            end
        end
        rd = d_rdata;
        er = d_err;
        d_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] rd, output int cyc);
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        cyc = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (if_ack) begin
                cyc = c;
                break;
            end
        end
        rd = if_rdata;
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({busy, if_ack, d_ack, d_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {busy, if_ack, d_ack, d_err});
        end
        total++;
        if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_rdata got if=%h d=%h want 0", if_rdata, d_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int cyc;
        do_data(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, cyc);
        total++;
        if (cyc !== 2 || er !== 1'b0) begin
            bad++;
            $display("FAIL sw_timing got cyc=%0d err=%b want cyc=2 err=0", cyc, er);
        end
        do_data(1'b0, 32'h10, 3'b010, 32'h0, rd, er, cyc);
        total++;
        if (cyc !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL lw got cyc=%0d err=%b rd=%h want 2 0 deadbeef", cyc, er, rd);
        end
    endtask

    task automatic test_sizes();
        logic [31:0] rd; logic er; int cyc;
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            do_data(1'b0, addrs[i], f3s[i], 32'h0, rd, er, cyc);
            total++;
            if (cyc !== 2 || er !== 1'b0 || rd !== exps[i]) begin
                bad++;
                $display("FAIL load_size%0d got cyc=%0d err=%b rd=%h want 2 0 %h",
                         i, cyc, er, rd, exps[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int cyc;
        do_data(1'b1, 32'h11, 3'b001, 32'h1234, rd, er, cyc);
        total++;
        if (cyc !== 2 || er !== 1'b1 || rd !== 32'd0) begin
            bad++;
            $display("FAIL sh_misaligned got cyc=%0d err=%b rd=%h want 2 1 0", cyc, er, rd);
        end
        do_data(1'b0, 32'h10, 3'b010, 32'h0, rd, er, cyc);
        total++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL mem_unchanged got err=%b rd=%h want 0 deadbeef", er, rd);
        end
        do_data(1'b0, 32'h10, 3'b011, 32'h0, rd, er, cyc);
        total++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            bad++;
            $display("FAIL illegal_f3 got err=%b rd=%h want 1 0", er, rd);
        end
        do_data(1'b0, 32'h12, 3'b010, 32'h0, rd, er, cyc);
        total++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            bad++;
            $display("FAIL lw_misaligned got err=%b rd=%h want 1 0", er, rd);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] rd, drd, ird; logic er; int cyc, dcyc, icyc; logic both;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_funct3 = 3'b010;
        if_req = 1'b1; if_addr = 32'h10;
        dcyc = 0; icyc = 0; both = 1'b0; drd = '0; ird = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (d_ack && if_ack) both = 1'b1;
            if (d_ack && dcyc == 0) begin
                dcyc = c; drd = d_rdata; d_req = 1'b0;
            end
            if (if_ack && icyc == 0) begin
                icyc = c; ird = if_rdata; if_req = 1'b0;
            end
            if (dcyc != 0 && icyc != 0) break;
        end
        d_req = 1'b0; if_req = 1'b0;
        total++;
        if (dcyc !== 2 || icyc !== 5 || both !== 1'b0) begin
            bad++;
            $display("FAIL arb_order got d=%0d if=%0d both=%b want 2 5 0", dcyc, icyc, both);
        end
        total++;
        if (drd !== 32'hDEADBEEF || ird !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL arb_data got d=%h if=%h want deadbeef", drd, ird);
        end
        do_data(1'b1, 32'h14, 3'b010, 32'h55667788, rd, er, cyc);
        do_fetch(32'h12, rd, cyc);
        total++;
        if (cyc !== 2 || rd !== 32'h7788DEAD) begin
            bad++;
            $display("FAIL fetch_half got cyc=%0d rd=%h want 2 7788dead", cyc, rd);
        end
        do_fetch(32'h13, rd, cyc);
        total++;
        if (rd !== 32'h7788DEAD) begin
            bad++;
            $display("FAIL fetch_bit0 got rd=%h want 7788dead", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int cyc;
        do_data(1'b1, 32'h3FE, 3'b000, 32'hAA, rd, er, cyc);
        do_data(1'b1, 32'h3FF, 3'b000, 32'hBB, rd, er, cyc);
        do_data(1'b1, 32'h000, 3'b000, 32'hCC, rd, er, cyc);
        do_data(1'b1, 32'h001, 3'b000, 32'hDD, rd, er, cyc);
        do_fetch(32'h3FE, rd, cyc);
        total++;
        if (rd !== 32'hDDCCBBAA) begin
            bad++;
            $display("FAIL fetch_wrap got rd=%h want ddccbbaa", rd);
        end
        do_data(1'b0, 32'h400, 3'b100, 32'h0, rd, er, cyc);
        total++;
        if (rd !== 32'h000000CC || er !== 1'b0) begin
            bad++;
            $display("FAIL data_wrap got rd=%h err=%b want 000000cc 0", rd, er);
        end
        do_data(1'b0, 32'h3FE, 3'b101, 32'h0, rd, er, cyc);
        total++;
        if (rd !== 32'h0000BBAA) begin
            bad++;
            $display("FAIL lhu_top got rd=%h want 0000bbaa", rd);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int cyc; logic seen;
        do_data(1'b1, 32'h20, 3'b010, 32'h01020304, rd, er, cyc);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_funct3 = 3'b010; d_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL wait_busy got=%b want 1", busy);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({busy, if_ack, d_ack, d_err} !== 4'b0000 || if_rdata !== 32'd0 ||
            d_rdata !== 32'd0) begin
            bad++;
            $display("FAIL abort_outputs got flags=%b if=%h d=%h want 0",
                     {busy, if_ack, d_ack, d_err}, if_rdata, d_rdata);
        end
        d_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d_ack) seen = 1'b1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (d_ack) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_ack got ack=%b want 0", seen);
        end
        do_data(1'b0, 32'h20, 3'b010, 32'h0, rd, er, cyc);
        total++;
        if (rd !== 32'h01020304 || er !== 1'b0) begin
            bad++;
            $display("FAIL abort_mem got rd=%h err=%b want 01020304 0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_sizes();
        test_errors();
        test_arbitration();
        test_wrap();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
